// File: rtl/mac_sequencer_if.sv
// Handshake bundle between a host/operand source/result consumer and
// mac_sequencer. The master side is the host; the slave side is the sequencer.
interface mac_sequencer_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
);
  // Handshake rule for both streams: a transfer happens on a rising clock
  // edge where valid and ready are both high. The sender holds its data
  // stable while valid is high and ready is low, and ready never depends
  // on valid.
  logic             start;
  logic [CNT_W-1:0] len;
  logic             busy;
  logic             op_valid;
  logic             op_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] result;
  logic             ovf;

  modport master (
    output start, len, op_valid, op_a, op_b, res_ready,
    input  busy, op_ready, res_valid, result, ovf
  );

  modport slave (
    input  start, len, op_valid, op_a, op_b, res_ready,
    output busy, op_ready, res_valid, result, ovf
  );
endinterface

// File: rtl/mac_sequencer.sv
// Multiply-accumulate job sequencer: accepts len operand pairs, multiplies
// each (low WIDTH bits), pipes it through a product register and sums it
// into an accumulator, then offers the sum on a result handshake.
module mac_sequencer #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  mac_sequencer_if.slave      bus,
  output logic [1:0]          state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] prod_q, prod_d;
  logic             prod_v_q, prod_v_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, op_ready_q, res_valid_q;

  logic [WIDTH-1:0] prod_trunc;
  logic [WIDTH:0]   sum;

  // Product kept at WIDTH bits: truncation is silent and never flags ovf.
  assign prod_trunc = bus.op_a * bus.op_b;
  assign sum        = {1'b0, acc_q} + {1'b0, prod_q};

  // Next-state and datapath update for the job sequence.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    prod_d   = prod_q;
    prod_v_d = prod_v_q;
    rem_d    = rem_q;
    ovf_d    = ovf_q;

    // Pending product drains into the accumulator in RUN and FLUSH.
    if (prod_v_q && (state_q == RUN || state_q == FLUSH)) begin
      acc_d = sum[WIDTH-1:0];
      if (sum[WIDTH]) ovf_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          acc_d    = '0;
          ovf_d    = 1'b0;
          prod_v_d = 1'b0;
          if (bus.len != '0) begin
            rem_d   = bus.len;
            state_d = RUN;
          end else begin
            state_d = DONE;
          end
        end
      end
      RUN: begin
        if (bus.op_valid) begin
          prod_d   = prod_trunc;
          prod_v_d = 1'b1;
          rem_d    = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) state_d = FLUSH;
        end else begin
          prod_v_d = 1'b0;
        end
      end
      FLUSH: begin
        prod_v_d = 1'b0;
        state_d  = DONE;
      end
      DONE: begin
        if (bus.res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; handshake outputs are registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      prod_q      <= '0;
      prod_v_q    <= 1'b0;
      rem_q       <= '0;
      ovf_q       <= 1'b0;
      busy_q      <= 1'b0;
      op_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      prod_q      <= prod_d;
      prod_v_q    <= prod_v_d;
      rem_q       <= rem_d;
      ovf_q       <= ovf_d;
      busy_q      <= (state_d != IDLE);
      op_ready_q  <= (state_d == RUN);
      res_valid_q <= (state_d == DONE);
    end
  end

  assign bus.busy      = busy_q;
  assign bus.op_ready  = op_ready_q;
  assign bus.res_valid = res_valid_q;
  assign bus.result    = acc_q;
  assign bus.ovf       = ovf_q;
  assign state_o       = state_q;

endmodule
